// File: rtl/heap_writer_pkg.sv
// Shared definitions for the tagged-object heap: widths, type tags, allocation status, object sizes.
package heap_writer_pkg;

    localparam int unsigned LISP_ADDR_WIDTH = 16;
    localparam int unsigned LISP_DATA_WIDTH = 16;

    localparam logic [LISP_ADDR_WIDTH-1:0] LISP_HEAP_BASE = 16'h0100;

    localparam logic [LISP_DATA_WIDTH-1:0] TYPE_NUMBER    = 16'h0001;
    localparam logic [LISP_DATA_WIDTH-1:0] TYPE_CONS      = 16'h0002;
    localparam logic [LISP_DATA_WIDTH-1:0] TYPE_FUNC_PRIM = 16'h0003;

    typedef enum logic [1:0] {
        ALLOC_OK      = 2'd0,
        ALLOC_FULL    = 2'd1,
        ALLOC_BAD_TAG = 2'd2
    } alloc_status_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_TAG = 3'd1,
        ST_WR_W0  = 3'd2,
        ST_WR_W1  = 3'd3,
        ST_RESP   = 3'd4
    } hw_state_e;

    // Words occupied by an object including its tag word; 0 marks an unknown tag.
    function automatic logic [1:0] obj_words(input logic [LISP_DATA_WIDTH-1:0] tag);
        logic [1:0] words;
        words = 2'd0;
        case (tag)
            TYPE_NUMBER:    words = 2'd2;
            TYPE_CONS:      words = 2'd3;
            TYPE_FUNC_PRIM: words = 2'd2;
            default:        words = 2'd0;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/heap_writer.sv
// Bump allocator that writes tagged objects (tag, then fields) into the heap one word per cycle.
module heap_writer
    import heap_writer_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = LISP_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = LISP_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = ADDR_WIDTH'(LISP_HEAP_BASE),
    parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_tag,
    input  logic [DATA_WIDTH-1:0] req_word0,
    input  logic [DATA_WIDTH-1:0] req_word1,
    output logic                  resp_valid,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_status,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_busy,
    output logic [ADDR_WIDTH-1:0] free_ptr
);

    // One extra bit so a pointer sitting just past HEAP_LIMIT never wraps back into the heap.
    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    hw_state_e             state;
    hw_state_e             state_nx;
    logic [PTR_WIDTH-1:0]  fp_q;
    logic [PTR_WIDTH-1:0]  fp_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] word0_q;
    logic [DATA_WIDTH-1:0] word1_q;
    logic [1:0]            words_q;

    logic                  accept;
    logic [1:0]            req_words;
    logic [PTR_WIDTH-1:0]  req_last;
    alloc_status_e         acc_status;

    logic                  resp_valid_nx;
    logic [ADDR_WIDTH-1:0] resp_addr_nx;
    logic [1:0]            resp_status_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic                  mem_we_nx;
    logic [DATA_WIDTH-1:0] mem_wdata_nx;
    logic                  mem_busy_nx;

    assign req_ready = (state == ST_IDLE) && boot_done && rst;
    assign accept    = req_valid && req_ready;
    assign req_words = obj_words(LISP_DATA_WIDTH'(req_tag));
    assign req_last  = fp_q + PTR_WIDTH'(req_words) - PTR_WIDTH'(1);
    assign free_ptr  = fp_q[ADDR_WIDTH-1:0];

    // Classify the incoming request against the tag table and remaining heap space.
    always_comb begin
        acc_status = ALLOC_OK;
        if (req_words == 2'd0) begin
            acc_status = ALLOC_BAD_TAG;
        end else if (req_last > {1'b0, HEAP_LIMIT}) begin
            acc_status = ALLOC_FULL;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: write sequence for good requests, straight to response on error.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = (acc_status == ALLOC_OK) ? ST_WR_TAG : ST_RESP;
            ST_WR_TAG: state_nx = ST_WR_W0;
            ST_WR_W0:  state_nx = (words_q == 2'd3) ? ST_WR_W1 : ST_RESP;
            ST_WR_W1:  state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state; the tag write uses the request still on the inputs.
    always_comb begin
        resp_valid_nx  = 1'b0;
        resp_addr_nx   = resp_addr;
        resp_status_nx = resp_status;
        mem_addr_nx    = '0;
        mem_we_nx      = 1'b0;
        mem_wdata_nx   = '0;
        mem_busy_nx    = 1'b0;
        fp_nx          = fp_q;
        case (state_nx)
            ST_WR_TAG: begin
                mem_we_nx    = 1'b1;
                mem_busy_nx  = 1'b1;
                mem_addr_nx  = fp_q[ADDR_WIDTH-1:0];
                mem_wdata_nx = req_tag;
            end
            ST_WR_W0: begin
                mem_we_nx    = 1'b1;
                mem_busy_nx  = 1'b1;
                mem_addr_nx  = base_q + ADDR_WIDTH'(1);
                mem_wdata_nx = word0_q;
            end
            ST_WR_W1: begin
                mem_we_nx    = 1'b1;
                mem_busy_nx  = 1'b1;
                mem_addr_nx  = base_q + ADDR_WIDTH'(2);
                mem_wdata_nx = word1_q;
            end
            ST_RESP: begin
                resp_valid_nx = 1'b1;
                if (state == ST_IDLE) begin
                    resp_status_nx = acc_status;
                end else begin
                    resp_status_nx = ALLOC_OK;
                    resp_addr_nx   = base_q;
                    fp_nx          = {1'b0, base_q} + PTR_WIDTH'(words_q);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and free pointer; reset rewinds the heap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid  <= 1'b0;
            resp_addr   <= '0;
            resp_status <= ALLOC_OK;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_busy    <= 1'b0;
            fp_q        <= {1'b0, HEAP_BASE};
        end else begin
            resp_valid  <= resp_valid_nx;
            resp_addr   <= resp_addr_nx;
            resp_status <= resp_status_nx;
            mem_addr    <= mem_addr_nx;
            mem_we      <= mem_we_nx;
            mem_wdata   <= mem_wdata_nx;
            mem_busy    <= mem_busy_nx;
            fp_q        <= fp_nx;
        end
    end

    // Capture the request at accept; inputs are free to change afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q  <= '0;
            word0_q <= '0;
            word1_q <= '0;
            words_q <= 2'd0;
        end else if (accept) begin
            base_q  <= fp_q[ADDR_WIDTH-1:0];
            word0_q <= req_word0;
            word1_q <= req_word1;
            words_q <= req_words;
        end
    end

endmodule

// File: tb/tb_heap_writer.sv
// Scoreboard bench for heap_writer: two instances (full heap and a 4-word heap) against a reference allocator.
module tb_heap_writer;
    import heap_writer_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic boot_done = 1'b0;

    logic          req_valid   [ND];
    logic          req_ready   [ND];
    logic [DW-1:0] req_tag     [ND];
    logic [DW-1:0] req_word0   [ND];
    logic [DW-1:0] req_word1   [ND];
    logic          resp_valid  [ND];
    logic [AW-1:0] resp_addr   [ND];
    logic [1:0]    resp_status [ND];
    logic [AW-1:0] mem_addr    [ND];
    logic          mem_we      [ND];
    logic [DW-1:0] mem_wdata   [ND];
    logic          mem_busy    [ND];
    logic [AW-1:0] free_ptr    [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam logic [AW-1:0] LIM = (g == 0) ? 16'hFFFF : 16'h0103;
        heap_writer #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HEAP_BASE(16'h0100), .HEAP_LIMIT(LIM)
        ) dut (
            .clk(clk), .rst(rst), .boot_done(boot_done),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_tag(req_tag[g]), .req_word0(req_word0[g]), .req_word1(req_word1[g]),
            .resp_valid(resp_valid[g]), .resp_addr(resp_addr[g]), .resp_status(resp_status[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_busy(mem_busy[g]), .free_ptr(free_ptr[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [1:0]    status;
        logic [AW-1:0] addr;
        logic [AW-1:0] fp;
        int            cyc;
    } rsp_t;

    wr_t  wq [ND][$];
    rsp_t rq [ND][$];

    int checks = 0;
    int failures = 0;

    int model_fp  [ND];
    int model_lim [ND];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference allocator: object size from the tag, bump pointer, bounds check against the limit.
    function automatic void model(input int d, input logic [DW-1:0] tag, input logic [DW-1:0] w0,
                                  input logic [DW-1:0] w1, input int acc);
        int   words;
        rsp_t r;
        wr_t  w;
        logic [DW-1:0] field [3];
        field[0] = tag;
        field[1] = w0;
        field[2] = w1;
        if (tag == TYPE_NUMBER || tag == TYPE_FUNC_PRIM) words = 2;
        else if (tag == TYPE_CONS) words = 3;
        else words = 0;
        r.addr = '0;
        r.fp   = AW'(model_fp[d]);
        r.cyc  = acc;
        if (words == 0) begin
            r.status = ALLOC_BAD_TAG;
        end else if (model_fp[d] + words - 1 > model_lim[d]) begin
            r.status = ALLOC_FULL;
        end else begin
            for (int k = 0; k < words; k++) begin
                w.addr = AW'(model_fp[d] + k);
                w.data = field[k];
                w.cyc  = acc + k;
                wq[d].push_back(w);
            end
            r.status = ALLOC_OK;
            r.addr   = AW'(model_fp[d]);
            model_fp[d] = model_fp[d] + words;
            r.fp     = AW'(model_fp[d]);
            r.cyc    = acc + words;
        end
        rq[d].push_back(r);
    endfunction

    // Monitors: pop expectations whenever an instance writes memory or responds.
    for (genvar g = 0; g < ND; g++) begin : g_mon
        always @(negedge clk) begin
            wr_t  w;
            rsp_t r;
            if (rst) begin
                if (mem_we[g]) begin
                    if (wq[g].size() > 0) begin
                        w = wq[g].pop_front();
                        check($sformatf("wr_addr[%0d]", g), 32'(mem_addr[g]), 32'(w.addr));
                        check($sformatf("wr_data[%0d]", g), 32'(mem_wdata[g]), 32'(w.data));
                        check($sformatf("wr_cycle[%0d]", g), 32'(cyc), 32'(w.cyc));
                    end else begin
                        check($sformatf("unexpected_write[%0d]", g), 32'(mem_we[g]), 32'd0);
                    end
                end
                if (mem_busy[g] || mem_we[g])
                    check($sformatf("busy_vs_we[%0d]", g), 32'(mem_busy[g]), 32'(mem_we[g]));
                if (mem_busy[g])
                    check($sformatf("ready_while_busy[%0d]", g), 32'(req_ready[g]), 32'd0);
                if (resp_valid[g]) begin
                    if (rq[g].size() > 0) begin
                        r = rq[g].pop_front();
                        check($sformatf("resp_status[%0d]", g), 32'(resp_status[g]), 32'(r.status));
                        if (r.status == ALLOC_OK)
                            check($sformatf("resp_addr[%0d]", g), 32'(resp_addr[g]), 32'(r.addr));
                        check($sformatf("resp_free_ptr[%0d]", g), 32'(free_ptr[g]), 32'(r.fp));
                        check($sformatf("resp_cycle[%0d]", g), 32'(cyc), 32'(r.cyc));
                    end else begin
                        check($sformatf("unexpected_resp[%0d]", g), 32'(resp_valid[g]), 32'd0);
                    end
                end
            end
        end
    end

    // Present one request, hold it until accepted, then scramble the inputs.
    task automatic issue(input int d, input logic [DW-1:0] tag, input logic [DW-1:0] w0,
                         input logic [DW-1:0] w1, input bit drop_boot);
        int budget;
        @(negedge clk);
        req_tag[d]   = tag;
        req_word0[d] = w0;
        req_word1[d] = w1;
        req_valid[d] = 1'b1;
        budget = 0;
        while (!req_ready[d] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("accept_ready", 32'(req_ready[d]), 32'd1);
        if (req_ready[d]) begin
            model(d, tag, w0, w1, cyc + 1);
            @(posedge clk);
            #1;
            req_valid[d] = 1'b0;
            req_tag[d]   = DW'($urandom);
            req_word0[d] = DW'($urandom);
            req_word1[d] = DW'($urandom);
            if (drop_boot) begin
                boot_done = 1'b0;
                @(negedge clk);
                boot_done = 1'b1;
            end
        end else begin
            req_valid[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((wq[0].size() + wq[1].size() + rq[0].size() + rq[1].size()) != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", 32'(wq[0].size() + wq[1].size() + rq[0].size() + rq[1].size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t;
        int d;
        int sel;
        for (int i = 0; i < ND; i++) begin
            req_valid[i] = 1'b0;
            req_tag[i]   = '0;
            req_word0[i] = '0;
            req_word1[i] = '0;
            model_fp[i]  = 32'h0100;
        end
        model_lim[0] = 32'hFFFF;
        model_lim[1] = 32'h0103;

        // Reset held low for three cycles with boot already done.
        rst = 1'b0;
        boot_done = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_free_ptr", 32'(free_ptr[0]), 32'h0100);
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_status", 32'(resp_status[0]), 32'(ALLOC_OK));
        check("rst_resp_addr", 32'(resp_addr[0]), 32'd0);
        check("rst_mem_we", 32'(mem_we[0]), 32'd0);
        check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata[0]), 32'd0);
        check("rst_mem_busy", 32'(mem_busy[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready[0]), 32'd1);

        // NUMBER then CONS then a bad tag on the full-size heap.
        issue(0, TYPE_NUMBER, 16'h002A, 16'h1234, 1'b0);
        drain();
        check("t1_free_ptr", 32'(free_ptr[0]), 32'h0102);
        issue(0, TYPE_CONS, 16'h0100, 16'h0000, 1'b0);
        drain();
        check("t2_free_ptr", 32'(free_ptr[0]), 32'h0105);
        issue(0, 16'h00FF, 16'hAAAA, 16'h5555, 1'b0);
        drain();
        check("t3_free_ptr", 32'(free_ptr[0]), 32'h0105);

        // Small heap: exact fit, then FULL that persists.
        issue(1, TYPE_NUMBER, 16'h0001, 16'h0000, 1'b0);
        issue(1, TYPE_NUMBER, 16'h0002, 16'h0000, 1'b0);
        issue(1, TYPE_CONS, 16'h0003, 16'h0004, 1'b0);
        issue(1, TYPE_FUNC_PRIM, 16'h0005, 16'h0000, 1'b0);
        drain();
        check("t4_free_ptr", 32'(free_ptr[1]), 32'h0104);

        // Back-to-back requests: the second waits out the first write sequence.
        issue(0, TYPE_FUNC_PRIM, 16'hBEEF, 16'h0000, 1'b1);
        issue(0, TYPE_CONS, 16'hCAFE, 16'hF00D, 1'b0);
        issue(0, TYPE_NUMBER, 16'h7777, 16'h0000, 1'b0);
        drain();
        check("t5_free_ptr", 32'(free_ptr[0]), 32'h010C);

        // Reset during the car write of a CONS.
        issue(0, TYPE_CONS, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_mem_we", 32'(mem_we[0]), 32'd0);
        check("t6_mem_busy", 32'(mem_busy[0]), 32'd0);
        check("t6_free_ptr", 32'(free_ptr[0]), 32'h0100);
        check("t6_resp_valid", 32'(resp_valid[0]), 32'd0);
        for (int i = 0; i < ND; i++) begin
            wq[i].delete();
            rq[i].delete();
            model_fp[i] = 32'h0100;
        end
        boot_done = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_ready_no_boot0", 32'(req_ready[0]), 32'd0);
            check("t6_ready_no_boot1", 32'(req_ready[1]), 32'd0);
        end
        boot_done = 1'b1;
        issue(0, TYPE_NUMBER, 16'h0042, 16'h0000, 1'b0);
        drain();
        check("t6_after_free_ptr", 32'(free_ptr[0]), 32'h0102);

        // Randomized mix over both heaps.
        for (int n = 0; n < 150; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 3) t = TYPE_NUMBER;
            else if (sel < 6) t = TYPE_CONS;
            else if (sel < 8) t = TYPE_FUNC_PRIM;
            else t = DW'($urandom);
            issue(d, t, DW'($urandom), DW'($urandom), ($urandom_range(0, 7) == 0));
        end
        drain();
        check("final_free_ptr0", 32'(free_ptr[0]), 32'(AW'(model_fp[0])));
        check("final_free_ptr1", 32'(free_ptr[1]), 32'(AW'(model_fp[1])));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
